// File: rtl/uart_tx_sequencer.sv
// -----------------------------------------------------------------------------
// uart_tx_sequencer
//
// Purpose:
//   Generates a run of incrementing data bytes for a UART TX PHY using a
//   tx_start / end_of_byte handshake. A space-style delimiter goes between
//   data bytes in a row. A CR/LF pair ends each row and the run. A
//   programmable millisecond delay goes between a separator and the next
//   data byte.
//
// Optional feature (compile-time macro UART_TX_SEQ_HEX_ASCII_EN):
//   When defined, each data byte goes out as two uppercase ASCII hex
//   characters, upper nibble first, with one handshake per character.
//   When undefined, the raw byte is sent and the extra states do not exist.
//
// Ports:
//   clk           in   system clock, rising edge
//   reset         in   synchronous active-high reset
//   start         in   one-cycle run request, honoured only in IDLE
//   abort         in   terminates a run in progress
//   num_of_bytes  in   data bytes per run (latched on start)
//   row_width     in   data bytes per row, 0 = CR/LF only at end (latched)
//   speed         in   inter-byte delay in units of DELAY_UNIT_MS ms (latched)
//   data_seed     in   value of the first data byte (latched)
//   end_of_byte   in   PHY completion pulse
//   tx_start      out  one-cycle PHY start strobe
//   byte_to_send  out  byte presented to the PHY
//   byte_count    out  data bytes completed in the current/last run
//   busy          out  high whenever not IDLE
//   done          out  one-cycle pulse on normal completion
// -----------------------------------------------------------------------------
`default_nettype none

module uart_tx_sequencer #(
    parameter int unsigned CLK_FREQ      = 100_000_000,
    parameter int unsigned CNT_W         = 16,
    parameter int unsigned DELAY_UNIT_MS = 10,
    parameter logic [7:0]  DELIM         = 8'h20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] num_of_bytes,
    input  logic [CNT_W-1:0] row_width,
    input  logic [7:0]       speed,
    input  logic [7:0]       data_seed,
    input  logic             end_of_byte,
    output logic             tx_start,
    output logic [7:0]       byte_to_send,
    output logic [CNT_W-1:0] byte_count,
    output logic             busy,
    output logic             done
);

    // Clock cycles per millisecond; never allowed to drop below one.
    localparam int unsigned TICK_CYCLES = (CLK_FREQ / 1000 > 0) ? (CLK_FREQ / 1000) : 1;
    localparam int unsigned PRE_W       = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    // Wide enough for 255 * DELAY_UNIT_MS.
    localparam int unsigned MS_W        = 8 + $clog2(DELAY_UNIT_MS + 1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_CYCLES - 1);

    localparam logic [7:0] CHAR_CR = 8'h0D;
    localparam logic [7:0] CHAR_LF = 8'h0A;

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_SEND_DATA = 4'd1;
    localparam logic [3:0] S_WAIT_DATA = 4'd2;
    localparam logic [3:0] S_SEND_SEP  = 4'd3;
    localparam logic [3:0] S_WAIT_SEP  = 4'd4;
    localparam logic [3:0] S_SEND_LF   = 4'd5;
    localparam logic [3:0] S_WAIT_LF   = 4'd6;
    localparam logic [3:0] S_DELAY     = 4'd7;
    localparam logic [3:0] S_FINISH    = 4'd8;
`ifdef UART_TX_SEQ_HEX_ASCII_EN
    localparam logic [3:0] S_SEND_LO   = 4'd9;
    localparam logic [3:0] S_WAIT_LO   = 4'd10;

    // Uppercase ASCII hex digit for one nibble.
    function automatic logic [7:0] hex_char(input logic [3:0] nib);
        logic [7:0] c;
        if (nib < 4'd10) begin
            c = 8'h30 + {4'h0, nib};
        end else begin
            c = 8'h37 + {4'h0, nib};
        end
        return c;
    endfunction
`endif

    // First character sent for a data byte: raw byte or its upper hex digit.
    function automatic logic [7:0] first_char(input logic [7:0] b);
`ifdef UART_TX_SEQ_HEX_ASCII_EN
        return hex_char(b[7:4]);
`else
        return b;
`endif
    endfunction

    logic [3:0]       state_q,        state_d;
    logic [CNT_W-1:0] num_q,          num_d;
    logic [CNT_W-1:0] row_q,          row_d;
    logic [MS_W-1:0]  delay_ms_q,     delay_ms_d;
    logic [7:0]       cur_byte_q,     cur_byte_d;
    logic [CNT_W-1:0] col_q,          col_d;
    logic             sep_cr_q,       sep_cr_d;
    logic [PRE_W-1:0] pre_q,          pre_d;
    logic [MS_W-1:0]  ms_q,           ms_d;
    logic             tx_start_q,     tx_start_d;
    logic [7:0]       byte_to_send_q, byte_to_send_d;
    logic [CNT_W-1:0] byte_count_q,   byte_count_d;
    logic             busy_q,         busy_d;
    logic             done_q,         done_d;

    logic [CNT_W-1:0] cnt_inc_s;
    logic [CNT_W-1:0] col_inc_s;
    logic             row_end_s;
    logic             last_byte_s;
    logic             no_delay_s;

    // Quantities used when a data byte completes; the column counter avoids a
    // divider for the "byte_count mod row_width == 0" row-end test.
    assign cnt_inc_s   = byte_count_q + CNT_W'(1);
    assign col_inc_s   = col_q + CNT_W'(1);
    assign row_end_s   = (row_q != '0) && (col_inc_s == row_q);
    assign last_byte_s = (cnt_inc_s == num_q);
    // A zero delay skips the DELAY state so the next data byte follows the
    // separator's end_of_byte by a single cycle.
    assign no_delay_s  = (delay_ms_q == '0);

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_d        = state_q;
        num_d          = num_q;
        row_d          = row_q;
        delay_ms_d     = delay_ms_q;
        cur_byte_d     = cur_byte_q;
        col_d          = col_q;
        sep_cr_d       = sep_cr_q;
        pre_d          = pre_q;
        ms_d           = ms_q;
        byte_count_d   = byte_count_q;
        byte_to_send_d = byte_to_send_q;

        if (abort && (state_q != S_IDLE)) begin
            // Abort wins over end_of_byte: everything holds, only state leaves.
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        num_d        = num_of_bytes;
                        row_d        = row_width;
                        delay_ms_d   = MS_W'(speed) * MS_W'(DELAY_UNIT_MS);
                        cur_byte_d   = data_seed;
                        col_d        = '0;
                        sep_cr_d     = 1'b0;
                        byte_count_d = '0;
                        state_d      = (num_of_bytes == '0) ? S_FINISH : S_SEND_DATA;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_SEND_DATA: state_d = S_WAIT_DATA;
                S_WAIT_DATA: begin
                    if (end_of_byte) begin
`ifdef UART_TX_SEQ_HEX_ASCII_EN
                        state_d = S_SEND_LO;
`else
                        byte_count_d = cnt_inc_s;
                        cur_byte_d   = cur_byte_q + 8'd1;
                        col_d        = row_end_s ? '0 : col_inc_s;
                        sep_cr_d     = last_byte_s || row_end_s;
                        state_d      = S_SEND_SEP;
`endif
                    end else begin
                        state_d = S_WAIT_DATA;
                    end
                end
`ifdef UART_TX_SEQ_HEX_ASCII_EN
                S_SEND_LO: state_d = S_WAIT_LO;
                S_WAIT_LO: begin
                    if (end_of_byte) begin
                        byte_count_d = cnt_inc_s;
                        cur_byte_d   = cur_byte_q + 8'd1;
                        col_d        = row_end_s ? '0 : col_inc_s;
                        sep_cr_d     = last_byte_s || row_end_s;
                        state_d      = S_SEND_SEP;
                    end else begin
                        state_d = S_WAIT_LO;
                    end
                end
`endif
                S_SEND_SEP: state_d = S_WAIT_SEP;
                S_WAIT_SEP: begin
                    if (end_of_byte) begin
                        if (sep_cr_q) begin
                            state_d = S_SEND_LF;
                        end else begin
                            state_d = no_delay_s ? S_SEND_DATA : S_DELAY;
                        end
                    end else begin
                        state_d = S_WAIT_SEP;
                    end
                end
                S_SEND_LF: state_d = S_WAIT_LF;
                S_WAIT_LF: begin
                    if (end_of_byte) begin
                        if (byte_count_q == num_q) begin
                            state_d = S_FINISH;
                        end else begin
                            state_d = no_delay_s ? S_SEND_DATA : S_DELAY;
                        end
                    end else begin
                        state_d = S_WAIT_LF;
                    end
                end
                S_DELAY: begin
                    // 1 ms prescaler feeding a millisecond counter.
                    if (no_delay_s) begin
                        state_d = S_SEND_DATA;
                    end else if (pre_q == PRE_LAST) begin
                        pre_d = '0;
                        if (ms_q == (delay_ms_q - MS_W'(1))) begin
                            ms_d    = '0;
                            state_d = S_SEND_DATA;
                        end else begin
                            ms_d = ms_q + MS_W'(1);
                        end
                    end else begin
                        pre_d = pre_q + PRE_W'(1);
                    end
                end
                S_FINISH: state_d = S_IDLE;
                default:  state_d = S_IDLE;
            endcase
        end

        // Delay counters run only while in DELAY and restart on every entry.
        pre_d = (state_d == S_DELAY) ? pre_d : '0;
        ms_d  = (state_d == S_DELAY) ? ms_d  : '0;

        // Byte is loaded on entry to a SEND state and then held through WAIT.
        case (state_d)
            S_SEND_DATA: byte_to_send_d = first_char(cur_byte_d);
`ifdef UART_TX_SEQ_HEX_ASCII_EN
            S_SEND_LO:   byte_to_send_d = hex_char(cur_byte_d[3:0]);
`endif
            S_SEND_SEP:  byte_to_send_d = sep_cr_d ? CHAR_CR : DELIM;
            S_SEND_LF:   byte_to_send_d = CHAR_LF;
            default:     byte_to_send_d = byte_to_send_q;
        endcase

        case (state_d)
            S_SEND_DATA,
`ifdef UART_TX_SEQ_HEX_ASCII_EN
            S_SEND_LO,
`endif
            S_SEND_SEP,
            S_SEND_LF:   tx_start_d = 1'b1;
            default:     tx_start_d = 1'b0;
        endcase

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_FINISH);
    end

    // State, latched run parameters and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            num_q          <= '0;
            row_q          <= '0;
            delay_ms_q     <= '0;
            cur_byte_q     <= 8'h00;
            col_q          <= '0;
            sep_cr_q       <= 1'b0;
            pre_q          <= '0;
            ms_q           <= '0;
            tx_start_q     <= 1'b0;
            byte_to_send_q <= 8'h00;
            byte_count_q   <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            num_q          <= num_d;
            row_q          <= row_d;
            delay_ms_q     <= delay_ms_d;
            cur_byte_q     <= cur_byte_d;
            col_q          <= col_d;
            sep_cr_q       <= sep_cr_d;
            pre_q          <= pre_d;
            ms_q           <= ms_d;
            tx_start_q     <= tx_start_d;
            byte_to_send_q <= byte_to_send_d;
            byte_count_q   <= byte_count_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
        end
    end

    // Abort suppresses a strobe or done pulse already registered for this
    // cycle, so an aborted run never starts a new PHY byte or reports done.
    assign tx_start     = tx_start_q && !abort;
    assign done         = done_q && !abort;
    assign byte_to_send = byte_to_send_q;
    assign byte_count   = byte_count_q;
    assign busy         = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_sequencer.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_sequencer
//
// Directed self-checking bench for uart_tx_sequencer (default build, raw
// bytes). The DUT runs with a 10 kHz clock so one millisecond is 10 cycles.
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_uart_tx_sequencer;

    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             abort;
    logic [CNT_W-1:0] num_of_bytes;
    logic [CNT_W-1:0] row_width;
    logic [7:0]       speed;
    logic [7:0]       data_seed;
    logic             end_of_byte;
    logic             tx_start;
    logic [7:0]       byte_to_send;
    logic [CNT_W-1:0] byte_count;
    logic             busy;
    logic             done;

    int vectors  = 0;
    int fails    = 0;
    int done_cnt = 0;
    int txs_cnt  = 0;

    logic [7:0] exp_q[$];
    int         wait_log[$];

    always #5 clk = ~clk;

    uart_tx_sequencer #(
        .CLK_FREQ      (10_000),
        .CNT_W         (CNT_W),
        .DELAY_UNIT_MS (10),
        .DELIM         (8'h20)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .abort        (abort),
        .num_of_bytes (num_of_bytes),
        .row_width    (row_width),
        .speed        (speed),
        .data_seed    (data_seed),
        .end_of_byte  (end_of_byte),
        .tx_start     (tx_start),
        .byte_to_send (byte_to_send),
        .byte_count   (byte_count),
        .busy         (busy),
        .done         (done)
    );

    // Pulse counters for done and tx_start, sampled just after each edge.
    always @(posedge clk) begin
        #1;
        if (done === 1'b1) done_cnt++;
        if (tx_start === 1'b1) txs_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Accepted start: returns on the falling edge where the DUT is in SEND_DATA.
    task automatic launch(input logic [15:0] n, input logic [15:0] rw,
                          input logic [7:0] spd, input logic [7:0] seed);
        @(negedge clk);
        num_of_bytes = n;
        row_width    = rw;
        speed        = spd;
        data_seed    = seed;
        start        = 1'b1;
        @(negedge clk);
        start        = 1'b0;
    endtask

    // PHY model: for each expected byte, wait (bounded) for tx_start, check the
    // byte, check the strobe lasts one cycle, then return end_of_byte.
    task automatic serve(input string tag);
        int t;
        logic [7:0] b;
        while (exp_q.size() > 0) begin
            t = 0;
            while (tx_start !== 1'b1 && t < 400) begin
                @(negedge clk);
                t++;
            end
            chk({tag, "_txs"}, 32'(tx_start), 32'd1);
            wait_log.push_back(t);
            if (tx_start !== 1'b1) begin
                exp_q.delete();
                break;
            end
            b = exp_q.pop_front();
            chk({tag, "_byte"}, 32'(byte_to_send), 32'(b));
            @(negedge clk);
            chk({tag, "_one_cycle"}, 32'(tx_start), 32'd0);
            chk({tag, "_hold"}, 32'(byte_to_send), 32'(b));
            end_of_byte = 1'b1;
            @(negedge clk);
            end_of_byte = 1'b0;
        end
    endtask

    task automatic check_no_waits(input string tag);
        foreach (wait_log[i]) chk(tag, 32'(wait_log[i]), 32'd0);
    endtask

    initial begin
        int dc0;
        int t0;
        reset        = 1'b1;
        start        = 1'b0;
        abort        = 1'b0;
        end_of_byte  = 1'b0;
        num_of_bytes = '0;
        row_width    = '0;
        speed        = 8'd0;
        data_seed    = 8'd0;

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_tx_start", 32'(tx_start), 32'd0);
        chk("rst_byte", 32'(byte_to_send), 32'd0);
        chk("rst_count", 32'(byte_count), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Run 1: five bytes, no rows, no delay.
        dc0 = done_cnt;
        launch(16'd5, 16'd0, 8'd0, 8'h41);
        chk("t1_busy", 32'(busy), 32'd1);
        chk("t1_count0", 32'(byte_count), 32'd0);
        exp_q = '{8'h41, 8'h20, 8'h42, 8'h20, 8'h43, 8'h20, 8'h44, 8'h20, 8'h45, 8'h0D, 8'h0A};
        wait_log.delete();
        serve("t1");
        chk("t1_done", 32'(done), 32'd1);
        chk("t1_count", 32'(byte_count), 32'd5);
        @(negedge clk);
        chk("t1_done_end", 32'(done), 32'd0);
        chk("t1_busy_end", 32'(busy), 32'd0);
        chk("t1_done_pulses", 32'(done_cnt - dc0), 32'd1);
        check_no_waits("t1_latency");

        // Run 2: rows of four.
        launch(16'd8, 16'd4, 8'd0, 8'h00);
        exp_q = '{8'h00, 8'h20, 8'h01, 8'h20, 8'h02, 8'h20, 8'h03, 8'h0D, 8'h0A,
                  8'h04, 8'h20, 8'h05, 8'h20, 8'h06, 8'h20, 8'h07, 8'h0D, 8'h0A};
        wait_log.delete();
        serve("t2");
        chk("t2_done", 32'(done), 32'd1);
        chk("t2_count", 32'(byte_count), 32'd8);
        chk("t2_lf1_lat", 32'(wait_log[8]), 32'd0);
        chk("t2_lf2_lat", 32'(wait_log[17]), 32'd0);
        check_no_waits("t2_latency");

        // Run 3: speed 1 = 10 ms = 100 cycles between the space and byte 2.
        launch(16'd2, 16'd0, 8'd1, 8'h50);
        exp_q = '{8'h50, 8'h20, 8'h51, 8'h0D, 8'h0A};
        wait_log.delete();
        serve("t3");
        chk("t3_gap", 32'((wait_log[2] >= 99) && (wait_log[2] <= 101)), 32'd1);
        chk("t3_lf_lat", 32'(wait_log[4]), 32'd0);
        chk("t3_done_no_delay", 32'(done), 32'd1);
        chk("t3_count", 32'(byte_count), 32'd2);

        // Run 4: abort coincident with end_of_byte of the space after byte 3.
        launch(16'd5, 16'd0, 8'd0, 8'h10);
        exp_q = '{8'h10, 8'h20, 8'h11, 8'h20, 8'h12};
        wait_log.delete();
        serve("t4");
        chk("t4_sep_txs", 32'(tx_start), 32'd1);
        chk("t4_sep_byte", 32'(byte_to_send), 32'h20);
        @(negedge clk);
        dc0 = done_cnt;
        end_of_byte = 1'b1;
        abort       = 1'b1;
        @(negedge clk);
        end_of_byte = 1'b0;
        abort       = 1'b0;
        chk("t4_abort_busy", 32'(busy), 32'd0);
        chk("t4_abort_count", 32'(byte_count), 32'd3);
        chk("t4_abort_txs", 32'(tx_start), 32'd0);
        repeat (5) @(negedge clk);
        chk("t4_no_done", 32'(done_cnt - dc0), 32'd0);
        chk("t4_idle", 32'(busy), 32'd0);
        launch(16'd2, 16'd0, 8'd0, 8'h30);
        chk("t4_restart_count", 32'(byte_count), 32'd0);
        exp_q = '{8'h30, 8'h20, 8'h31, 8'h0D, 8'h0A};
        serve("t4r");
        chk("t4r_done", 32'(done), 32'd1);
        chk("t4r_count", 32'(byte_count), 32'd2);

        // Run 5: zero-length run, then a start pulse while busy is ignored.
        t0 = txs_cnt;
        launch(16'd0, 16'd0, 8'd0, 8'h00);
        chk("t5_done", 32'(done), 32'd1);
        chk("t5_busy", 32'(busy), 32'd1);
        chk("t5_count", 32'(byte_count), 32'd0);
        num_of_bytes = 16'd3;
        data_seed    = 8'h77;
        start        = 1'b1;
        @(negedge clk);
        start        = 1'b0;
        chk("t5_idle", 32'(busy), 32'd0);
        chk("t5_done_end", 32'(done), 32'd0);
        repeat (20) @(negedge clk);
        chk("t5_ignored", 32'(txs_cnt - t0), 32'd0);
        chk("t5_still_idle", 32'(busy), 32'd0);

        // Run 6: reset while in DELAY.
        launch(16'd3, 16'd0, 8'd2, 8'h60);
        exp_q = '{8'h60, 8'h20};
        serve("t6");
        repeat (10) @(negedge clk);
        chk("t6_in_delay", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("t6_rst_txs", 32'(tx_start), 32'd0);
        chk("t6_rst_byte", 32'(byte_to_send), 32'd0);
        chk("t6_rst_count", 32'(byte_count), 32'd0);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_done", 32'(done), 32'd0);
        reset = 1'b0;
        t0 = txs_cnt;
        repeat (250) @(negedge clk);
        chk("t6_quiet", 32'(txs_cnt - t0), 32'd0);
        chk("t6_idle", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
